// File: rtl/line_follower_pwm_ctrl.sv
// line_follower_pwm_ctrl: two-motor line follower drive with debounced IR sensing, PWM, dead-time and search/halt FSM
module line_follower_pwm_ctrl #(
    parameter int N_SENS        = 5,
    parameter int PWM_W         = 8,
    parameter int BASE_DUTY     = 200,
    parameter int TURN_DUTY     = 80,
    parameter int DEBOUNCE      = 4,
    parameter int SEARCH_CYCLES = 1000,
    parameter int DEAD          = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_SENS-1:0] sens,
    input  logic [2:0]        cmd,
    input  logic              cmd_valid,
    output logic              m1a,
    output logic              m1b,
    output logic              m2a,
    output logic              m2b,
    output logic [1:0]        state_o,
    output logic              line_lost
);
    localparam int HALF = N_SENS / 2;
    localparam int CW   = $clog2(N_SENS + 1);
    localparam int DBW  = $clog2(DEBOUNCE + 1);
    localparam int SCW  = $clog2(SEARCH_CYCLES + 1);
    localparam int DW   = $clog2(DEAD + 1);
    localparam logic [PWM_W-1:0] BD = PWM_W'(BASE_DUTY);
    localparam logic [PWM_W-1:0] TD = PWM_W'(TURN_DUTY);
    localparam logic [2:0] C_AUTO = 3'd0, C_FWD = 3'd1, C_RIGHT = 3'd2, C_LEFT = 3'd3, C_REV = 3'd5;
    localparam logic [1:0] D_OFF = 2'd0, D_FWD = 2'd1, D_REV = 2'd2;

    typedef enum logic [1:0] {MANUAL = 2'd0, TRACK = 2'd1, SEARCH = 2'd2, HALT = 2'd3} state_t;

    state_t            r_state, w_state_n;
    logic [2:0]        r_act, w_act_n;
    logic              r_side, w_side_n;
    logic [SCW-1:0]    r_scnt, w_scnt_n;
    logic [PWM_W-1:0]  r_cnt;
    logic [N_SENS-1:0] r_s1, r_s2, w_deb;
    logic [CW-1:0]     w_l, w_r;
    logic              w_seen, w_cmd_ok;
    logic [1:0]        w_dir [2];
    logic [PWM_W-1:0]  w_duty [2];
    logic [1:0]        w_pa, w_pb;

    // Two-flop synchroniser, idling white so reset never looks like a line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= '1;
            r_s2 <= '1;
        end else begin
            r_s1 <= sens;
            r_s2 <= r_s1;
        end
    end

    genvar g;
    for (g = 0; g < N_SENS; g++) begin : g_deb
        logic           r_b;
        logic [DBW-1:0] r_c;
        // Accept a new level only after DEBOUNCE consecutive differing samples
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_b <= 1'b1;
                r_c <= '0;
            end else if (r_s2[g] == r_b) begin
                r_c <= '0;
            end else if (r_c == DBW'(DEBOUNCE - 1)) begin
                r_b <= r_s2[g];
                r_c <= '0;
            end else begin
                r_c <= r_c + 1'b1;
            end
        end
        assign w_deb[g] = r_b;
    end

    assign w_seen   = ~&w_deb;
    assign w_cmd_ok = cmd_valid && (cmd <= C_REV);

    // Black-sensor counts of the left and right halves; a centre sensor is excluded
    always_comb begin
        w_l = '0;
        w_r = '0;
        for (int i = 0; i < HALF; i++) begin
            w_l = w_l + CW'(!w_deb[i]);
            w_r = w_r + CW'(!w_deb[N_SENS-HALF+i]);
        end
    end

    // State, manual action, last steering side and search timer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= MANUAL;
            r_act   <= 3'd4;
            r_side  <= 1'b0;
            r_scnt  <= '0;
        end else begin
            r_state <= w_state_n;
            r_act   <= w_act_n;
            r_side  <= w_side_n;
            r_scnt  <= w_scnt_n;
        end
    end

    // Sensor-driven transitions, then a valid command overrides them
    always_comb begin
        w_state_n = r_state;
        w_act_n   = r_act;
        w_side_n  = r_side;
        w_scnt_n  = r_scnt;
        case (r_state)
            TRACK: begin
                if (!w_seen) begin
                    w_state_n = SEARCH;
                    w_scnt_n  = '0;
                end else if (w_l > w_r) begin
                    w_side_n = 1'b0;
                end else if (w_r > w_l) begin
                    w_side_n = 1'b1;
                end
            end
            SEARCH: begin
                if (w_seen) w_state_n = TRACK;
                else if (r_scnt == SCW'(SEARCH_CYCLES - 1)) w_state_n = HALT;
                else w_scnt_n = r_scnt + 1'b1;
            end
            default: ;
        endcase
        if (w_cmd_ok) begin
            w_state_n = (cmd == C_AUTO) ? TRACK : MANUAL;
            w_act_n   = (cmd == C_AUTO) ? r_act : cmd;
        end
    end

    // Per-motor direction and duty request for the current state
    always_comb begin
        w_dir[0]  = D_OFF;
        w_dir[1]  = D_OFF;
        w_duty[0] = BD;
        w_duty[1] = BD;
        case (r_state)
            MANUAL: begin
                w_dir[0] = (r_act == C_FWD || r_act == C_RIGHT) ? D_FWD : (r_act == C_REV) ? D_REV : D_OFF;
                w_dir[1] = (r_act == C_FWD || r_act == C_LEFT) ? D_FWD : (r_act == C_REV) ? D_REV : D_OFF;
            end
            TRACK: begin
                w_dir[0]  = D_FWD;
                w_dir[1]  = D_FWD;
                w_duty[0] = (w_l > w_r) ? TD : BD;
                w_duty[1] = (w_r > w_l) ? TD : BD;
            end
            SEARCH: begin
                w_dir[0]  = r_side ? D_FWD : D_REV;
                w_dir[1]  = r_side ? D_REV : D_FWD;
                w_duty[0] = TD;
                w_duty[1] = TD;
            end
            default: ;
        endcase
    end

    // Free-running PWM counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cnt <= '0;
        else r_cnt <= r_cnt + 1'b1;
    end

    for (g = 0; g < 2; g++) begin : g_mot
        logic          r_a, r_b, r_last, r_has, w_rev;
        logic [DW-1:0] r_dead;
        assign w_rev = (w_dir[g] != D_OFF) && r_has && ((w_dir[g] == D_REV) != r_last);
        // Remember last direction, hold pins low through a reversal, register the PWM pins
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_a    <= 1'b0;
                r_b    <= 1'b0;
                r_last <= 1'b0;
                r_has  <= 1'b0;
                r_dead <= '0;
            end else begin
                if (w_dir[g] != D_OFF) begin
                    r_last <= (w_dir[g] == D_REV);
                    r_has  <= 1'b1;
                end
                r_dead <= w_rev ? DW'(DEAD - 1) : (r_dead != '0) ? r_dead - 1'b1 : '0;
                r_a    <= !w_rev && (r_dead == '0) && (w_dir[g] == D_FWD) && (r_cnt < w_duty[g]);
                r_b    <= !w_rev && (r_dead == '0) && (w_dir[g] == D_REV) && (r_cnt < w_duty[g]);
            end
        end
        assign w_pa[g] = r_a;
        assign w_pb[g] = r_b;
    end

    assign m1a       = w_pa[0];
    assign m1b       = w_pb[0];
    assign m2a       = w_pa[1];
    assign m2b       = w_pb[1];
    assign state_o   = r_state;
    assign line_lost = (r_state == HALT);
endmodule
